// File: rtl/hb2_intp_filter.sv
// 23-tap half-band x2 polyphase interpolator: odd phase from a 12-entry delay line, even phase is d5.
// Optional build macro HB2_INTP_SAT_EN saturates the odd output instead of wrapping it.
//
// state  | meaning
// S_IDLE | no output pending; waiting for an input strobe
// S_ODD  | drive odd (midpoint) sample; a strobe here is an overrun and is dropped
// S_EVEN | drive even sample (d5); a strobe here is accepted back-to-back
module hb2_intp_filter #(
    parameter int DW = 35
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 clk_vld_in,
    input  logic signed [DW-1:0] dat_in,
    output logic                 clk_vld_out,
    output logic signed [DW-1:0] dat_out,
    output logic                 ovr_err
);

    localparam int SW = DW + 20;
    localparam logic signed [17:0] COEF [6] = '{18'sd82025, -18'sd23934, 18'sd11193,
                                                -18'sd5190, 18'sd2176, -18'sd734};

    typedef enum logic [1:0] {S_IDLE, S_ODD, S_EVEN} state_t;

    state_t state, state_nxt;
    logic shift_en, drop;
    logic signed [DW-1:0] dly [12];
    logic signed [DW:0] pre [6];
    logic signed [SW-1:0] acc, rnd;
    logic signed [DW+2:0] odd_full;
    logic signed [DW-1:0] odd_q;
    logic unused_lsb;

    always_comb begin
        state_nxt = state;
        shift_en  = 1'b0;
        drop      = 1'b0;
        case (state)
            S_IDLE: begin
                if (clk_vld_in) begin
                    shift_en  = 1'b1;
                    state_nxt = S_ODD;
                end
            end
            S_ODD: begin
                drop      = clk_vld_in;
                state_nxt = S_EVEN;
            end
            S_EVEN: begin
                if (clk_vld_in) begin
                    shift_en  = 1'b1;
                    state_nxt = S_ODD;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Symmetric pre-add pairs taps around the d5/d6 midpoint, then full-precision MAC.
    always_comb begin
        acc = '0;
        for (int k = 0; k < 6; k++) begin
            pre[k] = {dly[5-k][DW-1], dly[5-k]} + {dly[6+k][DW-1], dly[6+k]};
            acc    = acc + SW'(pre[k]) * SW'(COEF[k]);
        end
        rnd      = acc + SW'(65536);
        odd_full = rnd[SW-1:17];
    end

    assign unused_lsb = ^rnd[16:0];

`ifdef HB2_INTP_SAT_EN
    always_comb begin
        if (odd_full[DW+2:DW-1] != {4{odd_full[DW+2]}}) begin
            odd_q = odd_full[DW+2] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        end else begin
            odd_q = odd_full[DW-1:0];
        end
    end
`else
    logic unused_hi;
    assign odd_q     = odd_full[DW-1:0];
    assign unused_hi = ^odd_full[DW+2:DW];
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= S_IDLE;
            dat_out     <= '0;
            clk_vld_out <= 1'b0;
            ovr_err     <= 1'b0;
            for (int i = 0; i < 12; i++) dly[i] <= '0;
        end else begin
            state       <= state_nxt;
            clk_vld_out <= 1'b0;
            if (drop) ovr_err <= 1'b1;
            if (shift_en) begin
                dly[0] <= dat_in;
                for (int i = 11; i > 0; i--) dly[i] <= dly[i-1];
            end
            // Even reads d5 before this edge's shift, so back-to-back inputs stay gap-free.
            case (state)
                S_ODD: begin
                    clk_vld_out <= 1'b1;
                    dat_out     <= odd_q;
                end
                S_EVEN: begin
                    clk_vld_out <= 1'b1;
                    dat_out     <= dly[5];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hb2_intp_filter.sv
// Self-checking bench for hb2_intp_filter: input-history reference model plus directed cases.
module tb_hb2_intp_filter;

    localparam int DW = 35;

    logic                 clk = 1'b0;
    logic                 rstn = 1'b0;
    logic                 clk_vld_in = 1'b0;
    logic signed [DW-1:0] dat_in = '0;
    logic                 clk_vld_out;
    logic signed [DW-1:0] dat_out;
    logic                 ovr_err;

    hb2_intp_filter #(.DW(DW)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .clk_vld_in (clk_vld_in),
        .dat_in     (dat_in),
        .clk_vld_out(clk_vld_out),
        .dat_out    (dat_out),
        .ovr_err    (ovr_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: history of accepted inputs, newest first.
    longint hist[$];
    longint coef [6] = '{82025, -23934, 11193, -5190, 2176, -734};
    longint exp_d [4];
    bit     exp_v [4];
    longint last_d = 0;
    bit     exp_ovr = 0;
    int     last_acc = -100;
    int     cyc = 0;
    longint outs[$];

    function automatic longint fit(input longint r);
        longint lim;
        lim = longint'(1) <<< (DW - 1);
`ifdef HB2_INTP_SAT_EN
        if (r > lim - 1) return lim - 1;
        if (r < -lim) return -lim;
        return r;
`else
        return (r <<< (64 - DW)) >>> (64 - DW);
`endif
    endfunction

    function automatic longint odd_ref();
        longint s;
        s = 0;
        for (int k = 0; k < 6; k++) s += coef[k] * (hist[5-k] + hist[6+k]);
        return fit((s + 65536) >>> 17);
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (rstn && clk_vld_in) begin
            if (cyc - last_acc == 1) begin
                exp_ovr = 1;
            end else begin
                last_acc = cyc;
                hist.push_front(longint'(dat_in));
                hist.pop_back();
                exp_v[(cyc+1)%4] = 1;
                exp_d[(cyc+1)%4] = odd_ref();
                exp_v[(cyc+2)%4] = 1;
                exp_d[(cyc+2)%4] = hist[5];
            end
        end
    end

    always @(negedge clk) begin
        bit ev;
        ev = 0;
        if (!rstn) begin
            for (int i = 0; i < 4; i++) exp_v[i] = 0;
            last_d   = 0;
            exp_ovr  = 0;
            last_acc = -100;
            hist.delete();
            for (int i = 0; i < 12; i++) hist.push_back(0);
        end else begin
            ev = exp_v[cyc%4];
            if (ev) last_d = exp_d[cyc%4];
            exp_v[cyc%4] = 0;
        end
        chk("vld", longint'(clk_vld_out), longint'(ev));
        chk("dat", longint'(dat_out), last_d);
        chk("ovr", longint'(ovr_err), longint'(exp_ovr));
        if (clk_vld_out) outs.push_back(longint'(dat_out));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input longint v, input int gap);
        clk_vld_in = 1'b1;
        dat_in     = v[DW-1:0];
        step();
        clk_vld_in = 1'b0;
        repeat (gap - 1) step();
    endtask

    task automatic pulse_reset();
        rstn = 1'b0;
        step();
        step();
        rstn = 1'b1;
    endtask

    initial begin
        longint m, big, r;
        for (int i = 0; i < 12; i++) hist.push_back(0);

        // Reset held with random stimulus: outputs must stay cleared.
        repeat (6) begin
            clk_vld_in = 1'($urandom_range(0, 1));
            dat_in     = DW'({$urandom, $urandom});
            step();
        end
        clk_vld_in = 1'b0;
        rstn = 1'b1;
        step();

        // Impulse response.
        outs.delete();
        send(longint'(1) <<< 20, 2);
        repeat (15) send(0, 2);
        repeat (3) step();
        chk("imp_cnt", outs.size(), 32);
        if (outs.size() >= 32) begin
            chk("imp_o1", outs[0], -5872);
            chk("imp_e1", outs[1], 0);
            chk("imp_o2", outs[2], 17408);
            chk("imp_o3", outs[4], -41520);
            chk("imp_o4", outs[6], 89544);
            chk("imp_o5", outs[8], -191472);
            chk("imp_o6", outs[10], 656200);
            chk("imp_e6", outs[11], 1048576);
            chk("imp_o7", outs[12], 656200);
            chk("imp_o12", outs[22], -5872);
            chk("imp_e7", outs[13], 0);
        end

        // DC, back-to-back spacing.
        outs.delete();
        repeat (20) send(1000, 2);
        repeat (3) step();
        chk("dc_cnt", outs.size(), 40);
        if (outs.size() >= 40) begin
            chk("dc_odd", outs[38], 1000);
            chk("dc_even", outs[39], 1000);
        end

        // Overrun: second of two consecutive strobes dropped, flag sticky.
        send(123, 1);
        send(456, 2);
        repeat (5) send($signed(32'($urandom_range(0, 200000))) - 100000, $urandom_range(2, 3));
        repeat (2) step();
        chk("ovr_sticky", longint'(ovr_err), 1);

        // Reset pulsed while in S_EVEN.
        clk_vld_in = 1'b1;
        dat_in     = 500;
        step();
        clk_vld_in = 1'b0;
        step();
        rstn = 1'b0;
        step();
        chk("rst_vld", longint'(clk_vld_out), 0);
        chk("rst_dat", longint'(dat_out), 0);
        chk("rst_ovr", longint'(ovr_err), 0);
        rstn = 1'b1;
        repeat (3) step();
        outs.delete();
        send(longint'(1) <<< 20, 2);
        send(0, 2);
        repeat (2) step();
        chk("rst_restart", outs.size() > 0 ? outs[0] : 0, -5872);

        // Saturation / wrap of the odd output.
        pulse_reset();
        outs.delete();
        m = (longint'(1) <<< 34) - 1;
        foreach (coef[i]) begin end
        begin
            longint pat [12];
            pat = '{-m, m, -m, m, -m, m, m, -m, m, -m, m, -m};
            for (int i = 0; i < 12; i++) send(pat[i], 2);
        end
        repeat (3) step();
        big = (2 * m * 125252 + 65536) >>> 17;
`ifdef HB2_INTP_SAT_EN
        r = m;
`else
        r = (big <<< (64 - DW)) >>> (64 - DW);
`endif
        chk("sat_cnt", outs.size(), 24);
        if (outs.size() >= 23) chk("sat_o12", outs[22], r);

        // Random data with random spacing, including overruns.
        pulse_reset();
        repeat (200) begin
            longint v;
            v = longint'({$urandom, $urandom});
            v = (v <<< (64 - DW)) >>> (64 - DW);
            send(v, $urandom_range(1, 4));
        end
        repeat (5) step();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
